// File: rtl/fp16_mul_rr_arbiter_if.sv
// Requester/multiplier bundle for the shared FP16 multiplier arbiter.
// The slave side is the arbiter; the master side drives requests and models the multiplier.
interface fp16_mul_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic               en;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] a_flat;
  logic [NREQ*DW-1:0] b_flat;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      mul_a;
  logic [DW-1:0]      mul_b;
  logic               mul_vld_o;
  logic [DW-1:0]      mul_p;
  logic               mul_vld_i;
  logic [DW-1:0]      res_data;
  logic [NREQ-1:0]    res_vld;
  logic               busy;
  logic               err;

  modport master (
    output en, req, a_flat, b_flat, mul_p, mul_vld_i,
    input  gnt, mul_a, mul_b, mul_vld_o, res_data, res_vld, busy, err
  );

  modport slave (
    input  en, req, a_flat, b_flat, mul_p, mul_vld_i,
    output gnt, mul_a, mul_b, mul_vld_o, res_data, res_vld, busy, err
  );
endinterface

// File: rtl/fp16_mul_rr_arbiter.sv
// Round-robin issue of NREQ operand streams onto one pipelined FP16 multiplier,
// with a requester-ID tag pipe matched to the multiplier latency for result routing.
module fp16_mul_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int M_LAT = 6
) (
  input  logic clk,
  input  logic rst,
  fp16_mul_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(M_LAT + 2);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   gnt_id;
  logic            found;
  logic            grant;

  logic [DW-1:0]   mul_a_q;
  logic [DW-1:0]   mul_b_q;
  logic            issue_vld;
  logic [IW-1:0]   issue_id;

  logic            tag_vld [M_LAT];
  logic [IW-1:0]   tag_id  [M_LAT];
  logic            out_vld;
  logic [IW-1:0]   out_id;

  logic [DW-1:0]   res_data_q;
  logic [NREQ-1:0] res_vld_q;
  logic [CW-1:0]   inflight;
  logic            err_q;
  logic            ret_hit;
  logic            underflow;
  logic            ret_ok;
  logic            err_set;

  // Search upward from the requester after the last winner, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    found    = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[scan_idx]) begin
        found  = 1'b1;
        gnt_id = scan_idx;
      end
    end
  end

  assign grant   = found & bus.en & ~rst;
  assign bus.gnt = grant ? (NREQ'(1) << gnt_id) : '0;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IW'(NREQ - 1);
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      issue_vld <= 1'b0;
      issue_id  <= '0;
    end else begin
      issue_vld <= grant;
      if (grant) begin
        ptr      <= gnt_id;
        mul_a_q  <= bus.a_flat[int'(gnt_id)*DW +: DW];
        mul_b_q  <= bus.b_flat[int'(gnt_id)*DW +: DW];
        issue_id <= gnt_id;
      end
    end
  end

  // The issue register plus M_LAT stages line the tag up with mul_vld_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipe is reset, not left uninitialised, so rst drops in-flight products.
      for (int k = 0; k < M_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      tag_vld[0] <= issue_vld;
      tag_id[0]  <= issue_id;
      for (int k = 1; k < M_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign out_vld   = tag_vld[M_LAT-1];
  assign out_id    = tag_id[M_LAT-1];
  assign ret_hit   = bus.mul_vld_i & out_vld;
  assign underflow = ret_hit & (inflight == '0);
  assign ret_ok    = ret_hit & ~underflow;
  // Valid strobe and tag disagreeing covers both stray products and lost products.
  assign err_set   = (bus.mul_vld_i ^ out_vld) | underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q <= '0;
      res_vld_q  <= '0;
      inflight   <= '0;
      err_q      <= 1'b0;
    end else begin
      res_vld_q <= ret_ok ? (NREQ'(1) << out_id) : '0;
      if (ret_ok) res_data_q <= bus.mul_p;
      if (grant && !ret_ok)      inflight <= inflight + CW'(1);
      else if (!grant && ret_ok) inflight <= inflight - CW'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_vld_o = issue_vld;
  assign bus.res_data  = res_data_q;
  assign bus.res_vld   = res_vld_q;
  assign bus.busy      = (inflight != '0);
  assign bus.err       = err_q;
endmodule

// File: doc/fp16_mul_rr_arbiter.md
Name: fp16_mul_rr_arbiter

Overview:
- Shares one external pipelined FP16 multiplier (fixed latency M_LAT) among NREQ requesters: the dx, dAh, hC and xD product streams of the SSM datapath.
- Does round-robin operand issue, one product per cycle.
- Carries the requester ID through a tag pipeline aligned with the multiplier latency and routes each product back to its requester.
- Lets the datapath be time-multiplexed onto a single multiplier instead of one multiplier per stage.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 16, operand/product width (FP16 bit patterns, passed through untouched).
- M_LAT, 6, multiplier latency in cycles from mul_vld_o to mul_vld_i (>=1).
- IW (localparam), $clog2(NREQ), tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  arbitration enable; 0 = no new grants, in-flight products still drain.
- req  in  NREQ  per-requester request; requester i presents operands while req[i]=1.
- a_flat  in  NREQ*DW  operand A, requester i at [i*DW +: DW].
- b_flat  in  NREQ*DW  operand B, same packing.
- gnt  out  NREQ  one-hot combinational grant; operands accepted in the cycle gnt[i]=1.
- mul_a  out  DW  registered operand A to the multiplier.
- mul_b  out  DW  registered operand B to the multiplier.
- mul_vld_o  out  1  registered issue strobe to the multiplier.
- mul_p  in  DW  multiplier product.
- mul_vld_i  in  1  product valid from the multiplier.
- res_data  out  DW  registered product, shared by all requesters.
- res_vld  out  NREQ  one-hot registered; res_vld[i]=1 means res_data belongs to requester i.
- busy  out  1  1 while any product is in flight (inflight count != 0).
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async) values:
  - mul_a, mul_b, res_data = 0.
  - mul_vld_o, res_vld, busy, err = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Tag pipeline cleared; inflight = 0.
- Grant:
  - gnt = 0 when en=0 or req=0.
  - Otherwise exactly one bit set: the first set req bit searching upward from (ptr+1) mod NREQ, wrapping.
  - gnt is combinational from req/en/ptr; no grant during rst.
- Pointer: on a grant to i at cycle t, ptr <= i at t+1. Unchanged on idle cycles.
- Issue:
  - At t+1, mul_a/mul_b = granted operands, mul_vld_o = 1, and tag {1, i} enters stage 0 of the tag pipe.
  - Otherwise mul_vld_o = 0 and mul_a/mul_b hold their previous values.
- Tag pipe:
  - M_LAT stages; the tag issued with mul_vld_o at cycle t+1 reaches the pipe output at t+1+M_LAT, aligned with mul_vld_i.
- Return:
  - When mul_vld_i=1 and the output tag is valid with ID j: at the next edge res_data <= mul_p, res_vld <= onehot(j).
  - Otherwise res_vld <= 0 and res_data holds.
  - Grant-to-res_vld latency is exactly M_LAT+2 cycles.
- Throughput: one grant per cycle sustained. No backpressure on results; requesters must always accept res_vld.
- Fairness: with all req held high, the grant sequence is 0,1,..,NREQ-1,0,..; each requester gets 1 of every NREQ grants.
- inflight counter:
  - +1 on issue, -1 on return; both in the same cycle leaves it unchanged.
  - Range 0..M_LAT+1; busy = (inflight != 0).
- err (sticky until rst) is set on any of:
  - mul_vld_i=1 with no valid tag at the pipe output.
  - Valid tag at the pipe output with mul_vld_i=0.
  - inflight decrement at 0.
- Corrupt returns: on an err-triggering cycle res_vld stays 0 and the product is discarded.
- en deassert mid-stream: no new gnt; products already issued still return normally; busy falls after the last return.
- Request withdrawal: requester dropping req before grant loses nothing; the pointer is not advanced for it.
- Reset mid-operation: all in-flight products dropped, no res_vld after rst deasserts, ptr back to NREQ-1.

Test Plan:
- Single request: NREQ=4, M_LAT=6; req=0001, a=0x4000 (2.0), b=0x4200 (3.0) for one cycle; multiplier model returns 0x4600 after 6 cycles -> gnt=0001 in that cycle, mul_vld_o next cycle, res_vld=0001 and res_data=0x4600 exactly 8 cycles after the grant; busy high for the 7 cycles in between.
- Full contention: req=1111 held 12 cycles, requester i supplies a=i, b=0x3C00 -> grants 0,1,2,3 repeated 3 times; res_vld one-hot in the same order, each res_data equal to its requester's operand; no err.
- Wrap and skip: ptr=2 (last grant to 2), req=0011 -> next grant to 0, then 1, then 0.
- en gating: req=1111, en dropped after 2 grants for 5 cycles -> gnt=0000 in those cycles, the 2 products still return, busy falls to 0 after the last return, grants resume at requester 2.
- Protocol error: inject mul_vld_i=1 with an empty tag pipe -> err=1 next cycle and stays 1; res_vld remains 0.
- Reset mid-flight: 3 products in flight, pulse rst for 1 cycle -> no res_vld afterward, busy=0, err=0; first new grant with req=1111 goes to requester 0.
